// File: rtl/cdm_pkg.sv
// Shared definitions for the carry-disregard multiplier characterisation stages.
package cdm_pkg;

  localparam int CDM_PW    = 16;
  localparam int CDM_CNT_W = 17;
  localparam int CDM_ACC_W = 32;
  localparam int DRAIN_CYC = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } cdm_state_e;

endpackage

// File: rtl/cdm_abs_diff.sv
// Combinational unsigned error distance |a - b| between two products.
module cdm_abs_diff
  import cdm_pkg::*;
#(
  parameter int PW = CDM_PW
) (
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] b,
  output logic [PW-1:0] y
);

  // Subtract the smaller operand from the larger so no sign bit is needed.
  always_comb begin
    y = '0;
    if (a >= b) begin
      y = a - b;
    end else begin
      y = b - a;
    end
  end

endmodule

// File: rtl/cdm_err_stats.sv
// Batch error statistics (sum/max/count of error distances) for approximate products.
module cdm_err_stats
  import cdm_pkg::*;
#(
  parameter int PW    = CDM_PW,
  parameter int CNT_W = CDM_CNT_W,
  parameter int ACC_W = CDM_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    r_approx,
  input  logic [PW-1:0]    r_exact,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sum_ed,
  output logic [PW-1:0]    max_ed,
  output logic [CNT_W-1:0] err_count,
  output logic             overflow
);

  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYC - 1);

  cdm_state_e       state_r;
  logic [CNT_W-1:0] num_r;
  logic [CNT_W-1:0] acc_cnt_r;
  logic [1:0]       drain_cnt_r;
  logic             done_pend_r;
  logic             in_ready_r;
  logic             busy_r;
  logic             done_r;

  logic [PW-1:0]    ed_s;
  logic [PW-1:0]    ed1_r;
  logic             ne1_r;
  logic             v1_r;

  logic [ACC_W-1:0] sum_r;
  logic [PW-1:0]    max_r;
  logic [CNT_W-1:0] err_r;
  logic             ovf_r;
  logic [ACC_W:0]   sum_ext_s;

  logic xfer_s;
  logic start_ok_s;
  logic last_s;

  assign xfer_s     = in_valid && in_ready_r;
  assign start_ok_s = start && ((state_r == IDLE) || (state_r == DONE));
  assign last_s     = (acc_cnt_r == (num_r - CNT_W'(1)));

  cdm_abs_diff #(.PW(PW)) u_abs_diff (
    .a (r_exact),
    .b (r_approx),
    .y (ed_s)
  );

  // Batch control: handshake, drain timing and the delayed done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      num_r       <= '0;
      acc_cnt_r   <= '0;
      drain_cnt_r <= 2'd0;
      done_pend_r <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r      <= done_pend_r;
      done_pend_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            num_r     <= num_samples;
            acc_cnt_r <= '0;
            done_r    <= 1'b0;
            if (num_samples == '0) begin
              state_r     <= DONE;
              done_pend_r <= 1'b1;
            end else begin
              state_r    <= RUN;
              in_ready_r <= 1'b1;
              busy_r     <= 1'b1;
            end
          end else begin
            state_r <= state_r;
          end
        end
        RUN: begin
          if (xfer_s) begin
            acc_cnt_r <= acc_cnt_r + CNT_W'(1);
            if (last_s) begin
              state_r     <= DRAIN;
              in_ready_r  <= 1'b0;
              drain_cnt_r <= 2'd0;
            end
          end
        end
        DRAIN: begin
          // Two cycles let the final pair pass through S1 and into the S2 totals.
          if (drain_cnt_r == DRAIN_LAST) begin
            state_r     <= DONE;
            busy_r      <= 1'b0;
            done_pend_r <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r + 2'd1;
          end
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: register the error distance of each accepted pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r  <= 1'b0;
      ed1_r <= '0;
      ne1_r <= 1'b0;
    end else begin
      v1_r <= xfer_s;
      if (xfer_s) begin
        ed1_r <= ed_s;
        ne1_r <= (ed_s != '0);
      end
    end
  end

  // One spare bit catches the carry that signals saturation.
  always_comb begin
    sum_ext_s = {1'b0, sum_r} + {{(ACC_W + 1 - PW){1'b0}}, ed1_r};
  end

  // Stage 2: fold the registered distance into the batch totals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r <= '0;
      max_r <= '0;
      err_r <= '0;
      ovf_r <= 1'b0;
    end else if (start_ok_s) begin
      sum_r <= '0;
      max_r <= '0;
      err_r <= '0;
      ovf_r <= 1'b0;
    end else if (v1_r) begin
      if (sum_ext_s[ACC_W]) begin
        sum_r <= '1;
        ovf_r <= 1'b1;
      end else begin
        sum_r <= sum_ext_s[ACC_W-1:0];
      end
      if (ed1_r > max_r) begin
        max_r <= ed1_r;
      end
      err_r <= err_r + CNT_W'(ne1_r);
    end
  end

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign sum_ed    = sum_r;
  assign max_ed    = max_r;
  assign err_count = err_r;
  assign overflow  = ovf_r;

endmodule

// File: doc/cdm_err_stats.md
Name: cdm_err_stats

Overview:
- Downstream error-analysis stage for the carry-disregard approximate multipliers (8x8, 16-bit product).
- Consumes a stream of approximate/exact product pairs over a valid/ready handshake and computes, over a programmed batch of N samples:
  - the sum of error distances |exact - approx|,
  - the maximum error distance,
  - the count of erroneous products.
- Results are held stable after a one-cycle done pulse. They feed MED/ER figure-of-merit reporting in the characterisation harness.

Parameters:
- PW, 16, product width of both inputs and of max_ed.
- CNT_W, 17, width of num_samples and err_count; 17 allows an exhaustive 65536-pair sweep.
- ACC_W, 32, width of the sum_ed accumulator.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that launches a batch; honoured only in IDLE or DONE.
- num_samples  input  CNT_W  batch length N; sampled on the accepted start.
- in_valid  input  1  r_approx/r_exact pair is valid.
- in_ready  output  1  block accepts a pair this cycle.
- r_approx  input  PW  approximate multiplier product.
- r_exact  input  PW  exact reference product.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse when results are final.
- sum_ed  output  ACC_W  saturating sum of error distances.
- max_ed  output  PW  largest error distance in the batch.
- err_count  output  CNT_W  number of pairs with r_approx != r_exact.
- overflow  output  1  sticky; set if sum_ed saturated during the batch.

Behaviour:
- Reset: FSM=IDLE. in_ready, busy, done, overflow = 0. sum_ed, max_ed, err_count = 0. Pipeline valids = 0. Internal accepted counter = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start:
  - Latch N; clear sum_ed, max_ed, err_count, overflow and the accepted counter.
  - If N == 0, go to DONE and pulse done on the next cycle.
  - Otherwise go to RUN.
- start in RUN or DRAIN is ignored.
- RUN:
  - in_ready = 1 while accepted < N.
  - Transfer occurs when in_valid && in_ready; accepted increments.
  - When the N-th transfer occurs, go to DRAIN; in_ready = 0 from the next cycle.
- Pipeline, two registered stages:
  - S1 (edge of transfer): ed = |r_exact - r_approx| computed as an unsigned PW-bit magnitude; ne = (ed != 0); v1 = 1.
  - S2 (next edge, if v1):
    - sum_ed += ed, saturating at 2^ACC_W - 1; overflow set sticky on saturation.
    - max_ed = max(max_ed, ed).
    - err_count += ne.
- DRAIN: lasts exactly 2 cycles to empty S1/S2, then go to DONE.
- DONE: done = 1 for the first cycle only. Outputs hold until the next accepted start.
- Latency: the last transfer at edge k gives done high in the cycle after edge k+3. With back-to-back transfers, throughput is one pair per clock.
- Results are only guaranteed valid while done is high or in DONE. Mid-batch values are partial sums.
- in_valid while in_ready = 0 has no effect; the data is not sampled.
- rst asserted mid-batch aborts immediately to the reset state. No done is produced.

Decomposition:
- Shared package cdm_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN, DONE);
  - localparam DRAIN_CYC = 2;
  - the default PW/CNT_W/ACC_W constants, reused by the other characterisation stages.
- One sub-module is natural: cdm_abs_diff, a combinational PW-bit unsigned |a-b|.
- The accumulator, max and count logic stay inline in the top.

Test Plan:
- Reset then idle: all outputs 0, in_ready = 0, done never pulses without start.
- N=4, pairs (100,100),(90,96),(0,0),(200,180):
  - in_ready drops after the 4th transfer;
  - done pulses once;
  - sum_ed = 26, max_ed = 20, err_count = 2, overflow = 0.
- N=3 with in_valid gaps (valid on cycles 0, 3, 7), pairs (5,1),(1,5),(65535,0):
  - sum_ed = 65543, max_ed = 65535, err_count = 3;
  - done arrives 4 cycles after the last transfer.
- N=0 start: done pulses on the next cycle, all results 0, and in_ready never rises.
- ACC_W = 17 build, N=4, each pair ed = 65535:
  - sum_ed saturates at 131071;
  - overflow = 1 and stays 1 until the next start.
- start pulsed mid-RUN is ignored and results match the uninterrupted batch. Then rst is asserted mid-batch of a new run: outputs are 0 immediately, there is no done, and a fresh N=1 batch (7,3) gives sum_ed = 4.
